// File: rtl/prim_sec_dup_counter.sv
// Saturating up-counter kept as two redundant copies: the count and its complement.
// Any disagreement between the copies raises a sticky error flag.
module prim_sec_dup_counter #(
  parameter int               Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             en_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_next_o,
  output logic             sat_o,
  output logic             err_o
);

  function automatic logic [Width-1:0] sat_add(input logic [Width-1:0] a,
                                               input logic [Width-1:0] b);
    logic [Width:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[Width] ? {Width{1'b1}} : sum[Width-1:0];
  endfunction

  (* keep = "true", dont_touch = "true" *) logic [Width-1:0] cnt_q;
  (* keep = "true", dont_touch = "true" *) logic [Width-1:0] cnt_n_q;
  logic             err_q;
  logic [Width-1:0] cnt_d;
  logic [Width-1:0] cnt_n_d;
  logic             err_d;
  logic             mismatch;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = ResetValue;
    else if (set_i) cnt_d = set_cnt_i;
    else if (en_i)  cnt_d = sat_add(cnt_q, step_i);
  end

  // The shadow is advanced from its own state through a separate adder, never from cnt_d.
  always_comb begin
    cnt_n_d = cnt_n_q;
    if (clr_i)      cnt_n_d = ~ResetValue;
    else if (set_i) cnt_n_d = ~set_cnt_i;
    else if (en_i)  cnt_n_d = ~sat_add(~cnt_n_q, step_i);
  end

  always_comb begin
    mismatch = (cnt_q != ~cnt_n_q);
    err_d    = err_q | mismatch;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= ResetValue;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_n_q <= ~ResetValue;
    else       cnt_n_q <= cnt_n_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign sat_o      = (cnt_q == {Width{1'b1}});
  assign err_o      = err_d;

endmodule

// File: tb/tb_prim_sec_dup_counter.sv
// Self-checking bench for prim_sec_dup_counter: directed vector table, corner
// sequences, and random traffic against an arithmetic reference model.
module tb_prim_sec_dup_counter;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       set_i = 1'b0;
  logic [7:0] set_cnt_i = '0;
  logic       en_i = 1'b0;
  logic [7:0] step_i = '0;
  logic [7:0] cnt_o;
  logic [7:0] cnt_next_o;
  logic       sat_o;
  logic       err_o;

  int checks = 0;
  int failures = 0;

  prim_sec_dup_counter #(.Width(8), .ResetValue(8'h00)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .set_i(set_i), .set_cnt_i(set_cnt_i),
    .en_i(en_i), .step_i(step_i), .cnt_o(cnt_o), .cnt_next_o(cnt_next_o),
    .sat_o(sat_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       clr;
    logic       set;
    logic [7:0] sv;
    logic       en;
    logic [7:0] st;
    logic [7:0] exp;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic [7:0] sv,
                       input logic e, input logic [7:0] st);
    @(negedge clk);
    rst_i = r; clr_i = c; set_i = s; set_cnt_i = sv; en_i = e; step_i = st;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Reference: what the count becomes, from the stated priority and saturating sum.
  function automatic int model_next(int cur, bit c, bit s, int sv, bit e, int st);
    if (c) return 0;
    if (s) return sv;
    if (e) return (cur + st > 255) ? 255 : cur + st;
    return cur;
  endfunction

  initial begin
    int ref_cnt;
    int exp_n;
    bit r, c, s, e;
    logic [7:0] sv, st;

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 8'h05, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 8'h0A, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 8'h0F, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hFC, 1'b0, 8'h00, 8'hFC, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'hFF, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 8'hFF, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h33, 1'b1, 8'h02, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h07, 8'h20, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h20, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hE0, 8'hFF, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};

    // Reset held for two cycles
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    idle();
    #1;
    check("reset_cnt", cnt_o, 8'h00);
    check("reset_sat", sat_o, 1'b0);
    check("reset_err", err_o, 1'b0);
    check("reset_shadow", dut.cnt_n_q, 8'hFF);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, vecs[i].clr, vecs[i].set, vecs[i].sv, vecs[i].en, vecs[i].st);
      #1;
      check($sformatf("vec%0d_next", i), cnt_next_o, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cnt", i), cnt_o, vecs[i].exp);
      check($sformatf("vec%0d_sat", i), sat_o, vecs[i].exp_sat);
      check($sformatf("vec%0d_err", i), err_o, 1'b0);
    end

    // Shadow corruption at count 0x0F: error immediate and sticky through clr
    drive(1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 8'h00);
    idle();
    #1;
    check("pre_fault_cnt", cnt_o, 8'h0F);
    check("pre_fault_err", err_o, 1'b0);
    force dut.cnt_n_q = 8'hF4;
    #1;
    check("fault_err_same_cycle", err_o, 1'b1);
    @(posedge clk);
    #1;
    release dut.cnt_n_q;
    @(negedge clk);
    check("fault_err_held", err_o, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    idle();
    #1;
    check("fault_clr_cnt", cnt_o, 8'h00);
    check("fault_clr_shadow", dut.cnt_n_q, 8'hFF);
    check("fault_err_after_clr", err_o, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    check("fault_err_after_set", err_o, 1'b1);

    // Reset colliding with a set: reset wins and clears the error
    drive(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00);
    idle();
    #1;
    check("rst_vs_set_cnt", cnt_o, 8'h00);
    check("rst_vs_set_err", err_o, 1'b0);
    check("rst_vs_set_shadow", dut.cnt_n_q, 8'hFF);

    // Random traffic against the reference model
    ref_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 2) != 0);
      sv = 8'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      drive(r, c, s, sv, e, st);
      exp_n = model_next(ref_cnt, c, s, int'(sv), e, int'(st));
      #1;
      if (!r) check("rand_next", cnt_next_o, exp_n);
      @(posedge clk);
      ref_cnt = r ? 0 : exp_n;
      #1;
      check("rand_cnt", cnt_o, ref_cnt);
      check("rand_sat", sat_o, ref_cnt == 255);
      check("rand_err", err_o, 1'b0);
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
